nco_bcd_disp_mux: RTL and testbench
===================================

# nco_bcd_disp_mux

Parametrised successor to the NCO/counter/display top: a programmable NCO drives a DIGITS-wide BCD up/down counter with hold, clear and wrap flag. The count is shown on a time-multiplexed 7-segment bank with optional leading-zero blanking. It sits between the board clock and the segment/enable pins, with control inputs from switches or a host register block.

## Interface
Parameters:
- NCO_W, 32, width of NCO terminal-count input and internal NCO counter
- DIGITS, 6, number of BCD digits and of display enables (2..8)
- SCAN_DIV, 50000, clocks each digit stays enabled before the scan advances (>=2)
- DP_MASK, {DIGITS{1'b0}}, per-digit decimal-point pattern; bit k lights dp while digit k is enabled

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- i_nco_num  in  NCO_W  clocks per count tick; 0 = ticks disabled
- i_up_dn  in  1  1 = count up, 0 = count down
- i_hold  in  1  1 = freeze count (NCO keeps running, ticks ignored)
- i_clear  in  1  synchronous clear of count to 0
- i_blank_lz  in  1  1 = blank leading zeros (digit 0 never blanked)
- o_tick  out  1  one-cycle pulse per NCO terminal count
- o_wrap  out  1  one-cycle pulse when the count wraps (max->0 up, 0->max down)
- o_seg_enb  out  DIGITS  one-hot active-high digit enable
- o_seg_dp  out  1  decimal point, active-high
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-high

## Operation
- Reset values: NCO counter 0, count all digits 0, scan counter 0, scan index 0. Outputs: o_tick 0, o_wrap 0, o_seg_enb = 1 (digit 0), o_seg = 7'h3F, o_seg_dp = DP_MASK[0].
- NCO: nco_cnt increments every clock. When nco_cnt >= i_nco_num-1, nco_cnt <= 0 and o_tick <= 1 on the next edge; otherwise o_tick <= 0. The >= compare keeps a mid-run decrease of i_nco_num from running away. i_nco_num = 0: nco_cnt held at 0, no ticks. i_nco_num = 1: tick every cycle.
- Count priority: i_clear > i_hold > tick. A clear sets all digits to 0 and does not pulse o_wrap. On a tick with hold low, the count steps ±1 in BCD with ripple carry/borrow across digits.
- Wrap: up from all-9s gives all-0s; down from all-0s gives all-9s. Either case pulses o_wrap for one cycle, coincident with the count update.
- Digits never hold values 10..15.
- Scan: scan counter counts 0..SCAN_DIV-1. At the terminal value it returns to 0 and the scan index advances 0,1,..,DIGITS-1,0.
- Decode, ROM 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Blanking: when i_blank_lz = 1, digit k>0 is blanked (o_seg = 0, dp still per DP_MASK) if it and all higher digits are 0.
- o_seg_enb, o_seg and o_seg_dp are registered and change together; no output glitches between digits.

## Timing
- With i_nco_num = N, after rst_n goes high on edge 0, o_tick is high in the cycles following edges N, 2N, 3N, …
- The count register updates on the same edge that sets o_tick high, so the new count and o_tick are visible in the same cycle.
- o_seg/o_seg_dp reflect the count register one cycle later, for the currently enabled digit.
- Scan: each digit is enabled for exactly SCAN_DIV cycles. A full frame is DIGITS*SCAN_DIV cycles.
- i_clear, i_hold, i_up_dn and i_blank_lz are sampled every edge with no latency beyond one register.
- Reset mid-operation: on the first edge with rst_n = 0, all state and outputs return to their reset values, regardless of pending tick or scan position.
- A mode change (i_up_dn) between ticks applies to the next tick only.

## Test plan
- Reset/idle: rst_n low 2 cycles, then high with i_nco_num=0 -> o_seg_enb=6'b000001, o_seg=7'h3F, no o_tick for 1000 cycles, count stays 000000.
- Up count and wrap: DIGITS=6, i_nco_num=4, preload by counting to 999999 -> next tick gives 000000 with o_wrap high exactly 1 cycle. o_tick period 4 cycles.
- Down, clear and hold: i_up_dn=0 from 000000 -> 999999 with o_wrap. Then 3 ticks -> 999996. Assert i_hold across 2 ticks -> count unchanged. Pulse i_clear together with a tick -> 000000, no o_wrap.
- Scan and decode: SCAN_DIV=3, count 012345, DP_MASK=6'b000100 -> enable one-hot advances every 3 cycles. Segment sequence 6D,66,4F,5B,06,3F for digits 0..5. dp high only while digit 2 is enabled.
- Leading-zero blanking: count 000070, i_blank_lz=1 -> digits 2..5 show o_seg=0, digit 1 shows 7'h07, digit 0 shows 7'h3F. Count 000000 -> only digit 0 shows 3F.
- NCO retune and mid-run reset: with nco_cnt=9 and i_nco_num=20, change i_nco_num to 5 -> o_tick next cycle, then period 5. Assert rst_n low while the scan is at digit 3 -> outputs return to reset values on the next edge.

Source files
------------

// File: rtl/nco_bcd_disp_mux_if.sv
// Control and display pin bundle for nco_bcd_disp_mux.
// The master drives the controls; the slave is the counter/display block.
interface nco_bcd_disp_mux_if #(
    parameter int NCO_W  = 32,
    parameter int DIGITS = 6
);
    logic [NCO_W-1:0]  i_nco_num;
    logic              i_up_dn;
    logic              i_hold;
    logic              i_clear;
    logic              i_blank_lz;
    logic              o_tick;
    logic              o_wrap;
    logic [DIGITS-1:0] o_seg_enb;
    logic              o_seg_dp;
    logic [6:0]        o_seg;

    modport master (
        output i_nco_num, i_up_dn, i_hold, i_clear, i_blank_lz,
        input  o_tick, o_wrap, o_seg_enb, o_seg_dp, o_seg
    );

    modport slave (
        input  i_nco_num, i_up_dn, i_hold, i_clear, i_blank_lz,
        output o_tick, o_wrap, o_seg_enb, o_seg_dp, o_seg
    );
endinterface

// File: rtl/nco_bcd_disp_mux.sv
// NCO-paced BCD up/down counter shown on a scanned 7-segment bank.
// Segment, enable and dp outputs are registered together per digit.
module nco_bcd_disp_mux #(
    parameter int                NCO_W    = 32,
    parameter int                DIGITS   = 6,
    parameter int                SCAN_DIV = 50000,
    parameter logic [DIGITS-1:0] DP_MASK  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    nco_bcd_disp_mux_if.slave bus
);
    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int IX_W = $clog2(DIGITS);

    logic [NCO_W-1:0]           nco_q, nco_d;
    logic                       tick_q, tick_d;
    logic                       wrap_q, wrap_d;
    logic [DIGITS-1:0][3:0]     cnt_q, cnt_d;
    logic [SC_W-1:0]            scan_q, scan_d;
    logic [IX_W-1:0]            idx_q, idx_d;
    logic [DIGITS-1:0]          enb_q, enb_d;
    logic [6:0]                 seg_q, seg_d;
    logic                       dp_q, dp_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // NCO: terminal compare uses >= so a lowered period takes effect at once
    always_comb begin
        nco_d  = nco_q + NCO_W'(1);
        tick_d = 1'b0;
        if (bus.i_nco_num == '0) begin
            nco_d = '0;
        end else if (nco_q >= bus.i_nco_num - NCO_W'(1)) begin
            nco_d  = '0;
            tick_d = 1'b1;
        end
    end

    // BCD step with ripple carry/borrow; a carry out of the top digit is a wrap
    always_comb begin
        logic carry;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        carry  = 1'b1;
        if (bus.i_clear) begin
            cnt_d = '0;
        end else if (tick_d && !bus.i_hold) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (carry) begin
                    if (bus.i_up_dn) begin
                        if (cnt_q[k] == 4'd9) begin
                            cnt_d[k] = 4'd0;
                        end else begin
                            cnt_d[k] = cnt_q[k] + 4'd1;
                            carry    = 1'b0;
                        end
                    end else begin
                        if (cnt_q[k] == 4'd0) begin
                            cnt_d[k] = 4'd9;
                        end else begin
                            cnt_d[k] = cnt_q[k] - 4'd1;
                            carry    = 1'b0;
                        end
                    end
                end
            end
            wrap_d = carry;
        end
    end

    // Scan timer/index and the next displayed digit, blanked when leading
    always_comb begin
        logic nz;
        scan_d = scan_q + SC_W'(1);
        idx_d  = idx_q;
        if (scan_q == SC_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            if (idx_q == IX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IX_W'(1);
            end
        end
        enb_d        = '0;
        enb_d[idx_d] = 1'b1;
        nz           = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (IX_W'(j) >= idx_d && cnt_q[j] != 4'd0) begin
                nz = 1'b1;
            end
        end
        seg_d = seg7(cnt_q[idx_d]);
        if (bus.i_blank_lz && idx_d != '0 && !nz) begin
            seg_d = '0;
        end
        dp_d = DP_MASK[idx_d];
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nco_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
            scan_q <= '0;
            idx_q  <= '0;
            enb_q  <= DIGITS'(1);
            seg_q  <= 7'h3F;
            dp_q   <= DP_MASK[0];
        end else begin
            nco_q  <= nco_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            enb_q  <= enb_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign bus.o_tick    = tick_q;
    assign bus.o_wrap    = wrap_q;
    assign bus.o_seg_enb = enb_q;
    assign bus.o_seg     = seg_q;
    assign bus.o_seg_dp  = dp_q;
endmodule

// File: tb/tb_nco_bcd_disp_mux.sv
// Bench for nco_bcd_disp_mux: directed scenarios plus randomized
// stimulus against an arithmetic (decimal integer) reference model.
module tb_nco_bcd_disp_mux;
    localparam int             NCO_W = 32;
    localparam int             D     = 6;
    localparam int             SD    = 3;
    localparam logic [D-1:0]   DPM   = 6'b000100;
    localparam int             MAXC  = 999999;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    nco_bcd_disp_mux_if #(.NCO_W(NCO_W), .DIGITS(D)) bus ();

    nco_bcd_disp_mux #(
        .NCO_W(NCO_W), .DIGITS(D), .SCAN_DIV(SD), .DP_MASK(DPM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Reference model: count kept as a plain decimal integer
    int         m_nco = 0, m_cnt = 0, m_scan = 0, m_idx = 0;
    logic       m_tick, m_wrap, m_dp;
    logic [D-1:0] m_enb;
    logic [6:0] m_seg;

    always @(posedge clk) begin
        int old;
        old = m_cnt;
        if (!rst_n) begin
            m_nco = 0; m_cnt = 0; m_scan = 0; m_idx = 0;
            m_tick = 1'b0; m_wrap = 1'b0;
            m_enb = D'(1); m_seg = 7'h3F; m_dp = DPM[0];
        end else begin
            if (bus.i_nco_num == 0) begin
                m_nco = 0; m_tick = 1'b0;
            end else if (longint'(m_nco) >= longint'(bus.i_nco_num) - 1) begin
                m_nco = 0; m_tick = 1'b1;
            end else begin
                m_nco = m_nco + 1; m_tick = 1'b0;
            end
            m_wrap = 1'b0;
            if (bus.i_clear) begin
                m_cnt = 0;
            end else if (m_tick && !bus.i_hold) begin
                if (bus.i_up_dn) begin
                    if (m_cnt == MAXC) begin m_cnt = 0; m_wrap = 1'b1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin m_cnt = MAXC; m_wrap = 1'b1; end
                    else m_cnt = m_cnt - 1;
                end
            end
            if (m_scan == SD - 1) begin
                m_scan = 0; m_idx = (m_idx + 1) % D;
            end else begin
                m_scan = m_scan + 1;
            end
            m_enb = D'(1) << m_idx;
            if (bus.i_blank_lz && m_idx > 0 && old < p10(m_idx)) m_seg = 7'h00;
            else m_seg = seg7((old / p10(m_idx)) % 10);
            m_dp = DPM[m_idx];
        end
    end

    logic [6:0] fr_seg [D];
    logic       fr_dp  [D];

    // Capture the segment/dp value shown for each digit over one frame
    task automatic read_frame();
        for (int k = 0; k < D; k++) begin fr_seg[k] = 'x; fr_dp[k] = 1'bx; end
        repeat (D * SD + 1) begin
            @(negedge clk);
            for (int k = 0; k < D; k++) begin
                if (bus.o_seg_enb == (D'(1) << k)) begin
                    fr_seg[k] = bus.o_seg;
                    fr_dp[k]  = bus.o_seg_dp;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.i_nco_num = '0; bus.i_up_dn = 1'b1; bus.i_hold = 1'b0;
        bus.i_clear = 1'b0; bus.i_blank_lz = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_tick, bus.o_wrap, bus.o_seg_enb, bus.o_seg_dp, bus.o_seg}
            !== {1'b0, 1'b0, 6'b000001, 1'b0, 7'h3F}) begin
            failures++;
            $display("FAIL reset_state got=%b_%b_%b_%b_%h", bus.o_tick, bus.o_wrap,
                     bus.o_seg_enb, bus.o_seg_dp, bus.o_seg);
        end
        rst_n = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            checks++;
            if (bus.o_tick !== 1'b0 || bus.o_wrap !== 1'b0 || bus.o_seg !== 7'h3F) begin
                failures++;
                $display("FAIL idle tick=%b wrap=%b seg=%h want 0 0 3f",
                         bus.o_tick, bus.o_wrap, bus.o_seg);
            end
        end
    endtask

    task automatic test_up_wrap();
        int n, last, wraps;
        bit seen;
        bus.i_up_dn = 1'b0; bus.i_nco_num = 4;
        seen = 0;
        for (n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = bus.o_wrap;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL down_to_max wrap=0 want 1"); end
        bus.i_up_dn = 1'b1;
        last = -1; wraps = 0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            checks++;
            if ({bus.o_tick, bus.o_wrap, bus.o_seg_enb, bus.o_seg_dp, bus.o_seg}
                !== {m_tick, m_wrap, m_enb, m_dp, m_seg}) begin
                failures++;
                $display("FAIL up_model n=%0d got=%b%b_%b_%b_%h want=%b%b_%b_%b_%h", n,
                         bus.o_tick, bus.o_wrap, bus.o_seg_enb, bus.o_seg_dp, bus.o_seg,
                         m_tick, m_wrap, m_enb, m_dp, m_seg);
            end
            if (bus.o_tick) begin
                if (last >= 0) begin
                    checks++;
                    if (n - last != 4) begin
                        failures++;
                        $display("FAIL tick_period got=%0d want=4", n - last);
                    end
                end
                last = n;
            end
            if (bus.o_wrap) wraps++;
        end
        checks++;
        if (wraps != 1) begin
            failures++;
            $display("FAIL up_wrap_pulses got=%0d want=1", wraps);
        end
    endtask

    task automatic test_down_clear_hold();
        int n, t, v;
        bit seen;
        bus.i_nco_num = '0; bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0; bus.i_up_dn = 1'b0; bus.i_nco_num = 4;
        seen = 0;
        for (n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = bus.o_wrap;
            if (seen) begin
                checks++;
                if (bus.o_tick !== 1'b1) begin
                    failures++; $display("FAIL wrap_with_tick tick=%b want 1", bus.o_tick);
                end
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL down_wrap wrap=0 want 1"); end
        t = 0;
        for (n = 0; n < 40 && t < 3; n++) begin
            @(negedge clk);
            if (bus.o_tick) t++;
        end
        bus.i_nco_num = '0;
        checks++;
        if (t != 3) begin failures++; $display("FAIL down_ticks got=%0d want=3", t); end
        read_frame();
        for (int k = 0; k < D; k++) begin
            checks++;
            if (fr_seg[k] !== seg7((999996 / p10(k)) % 10)) begin
                failures++;
                $display("FAIL down_count digit=%0d got=%h want=%h", k, fr_seg[k],
                         seg7((999996 / p10(k)) % 10));
            end
        end
        bus.i_hold = 1'b1; bus.i_nco_num = 4; t = 0;
        for (n = 0; n < 40 && t < 2; n++) begin
            @(negedge clk);
            if (bus.o_tick) t++;
            checks++;
            if (bus.o_wrap !== 1'b0) begin
                failures++; $display("FAIL hold_wrap wrap=%b want 0", bus.o_wrap);
            end
        end
        bus.i_hold = 1'b0; bus.i_nco_num = '0;
        checks++;
        if (t != 2) begin failures++; $display("FAIL hold_ticks got=%0d want=2", t); end
        read_frame();
        for (int k = 0; k < D; k++) begin
            checks++;
            if (fr_seg[k] !== seg7((999996 / p10(k)) % 10)) begin
                failures++;
                $display("FAIL hold_count digit=%0d got=%h", k, fr_seg[k]);
            end
        end
        for (int r = 0; r < 2; r++) begin
            bus.i_nco_num = 4;
            for (n = 0; n < 20 && m_nco != 3; n++) @(negedge clk);
            bus.i_clear = 1'b1;
            @(negedge clk);
            bus.i_clear = 1'b0; bus.i_nco_num = '0;
            checks++;
            if (bus.o_tick !== 1'b1 || bus.o_wrap !== 1'b0) begin
                failures++;
                $display("FAIL clear_tick r=%0d tick=%b wrap=%b want 1 0", r,
                         bus.o_tick, bus.o_wrap);
            end
            read_frame();
            v = 0;
            for (int k = 0; k < D; k++) if (fr_seg[k] !== 7'h3F) v++;
            checks++;
            if (v != 0) begin
                failures++; $display("FAIL clear_count r=%0d bad_digits=%0d want 0", r, v);
            end
        end
    endtask

    task automatic count_to(input int target);
        int n;
        bus.i_nco_num = '0; bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0; bus.i_up_dn = 1'b1; bus.i_nco_num = 1;
        for (n = 0; n < 20000 && m_cnt != target; n++) @(negedge clk);
        bus.i_nco_num = '0;
        checks++;
        if (m_cnt != target) begin
            failures++; $display("FAIL count_to timeout got=%0d want=%0d", m_cnt, target);
        end
    endtask

    task automatic test_scan_decode();
        logic [6:0]   exp_seg [D];
        logic [D-1:0] prev;
        int           run, n;
        exp_seg = '{7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
        bus.i_blank_lz = 1'b0;
        count_to(12345);
        read_frame();
        for (int k = 0; k < D; k++) begin
            checks++;
            if (fr_seg[k] !== exp_seg[k] || fr_dp[k] !== (k == 2)) begin
                failures++;
                $display("FAIL scan_decode digit=%0d got=%h/%b want=%h/%b", k,
                         fr_seg[k], fr_dp[k], exp_seg[k], k == 2);
            end
        end
        @(negedge clk);
        prev = bus.o_seg_enb; run = 1;
        for (n = 0; n < 2 * D * SD; n++) begin
            @(negedge clk);
            checks++;
            if (!$onehot(bus.o_seg_enb)) begin
                failures++; $display("FAIL enb_onehot got=%b", bus.o_seg_enb);
            end
            if (bus.o_seg_enb == prev) begin
                run++;
            end else begin
                if (n >= SD) begin
                    checks++;
                    if (run != SD || bus.o_seg_enb != {prev[D-2:0], prev[D-1]}) begin
                        failures++;
                        $display("FAIL scan_dwell run=%0d want=%0d enb=%b prev=%b", run, SD,
                                 bus.o_seg_enb, prev);
                    end
                end
                run = 1; prev = bus.o_seg_enb;
            end
        end
    endtask

    task automatic test_blank();
        logic [6:0] exp_a [D];
        exp_a = '{7'h3F, 7'h07, 7'h00, 7'h00, 7'h00, 7'h00};
        count_to(70);
        bus.i_blank_lz = 1'b1;
        read_frame();
        for (int k = 0; k < D; k++) begin
            checks++;
            if (fr_seg[k] !== exp_a[k] || fr_dp[k] !== (k == 2)) begin
                failures++;
                $display("FAIL blank_70 digit=%0d got=%h/%b want=%h/%b", k,
                         fr_seg[k], fr_dp[k], exp_a[k], k == 2);
            end
        end
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        read_frame();
        for (int k = 0; k < D; k++) begin
            checks++;
            if (fr_seg[k] !== ((k == 0) ? 7'h3F : 7'h00)) begin
                failures++;
                $display("FAIL blank_0 digit=%0d got=%h", k, fr_seg[k]);
            end
        end
        bus.i_blank_lz = 1'b0;
    endtask

    task automatic test_retune_reset();
        int n;
        bus.i_up_dn = 1'b1; bus.i_nco_num = 20;
        for (n = 0; n < 40 && m_nco != 9; n++) @(negedge clk);
        bus.i_nco_num = 5;
        for (n = 0; n < 16; n++) begin
            @(negedge clk);
            checks++;
            if (bus.o_tick !== (n % 5 == 0)) begin
                failures++;
                $display("FAIL retune n=%0d tick=%b want=%b", n, bus.o_tick, n % 5 == 0);
            end
        end
        for (n = 0; n < 40 && bus.o_seg_enb != 6'b001000; n++) @(negedge clk);
        checks++;
        if (bus.o_seg_enb != 6'b001000) begin
            failures++; $display("FAIL wait_digit3 enb=%b", bus.o_seg_enb);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_tick, bus.o_wrap, bus.o_seg_enb, bus.o_seg_dp, bus.o_seg}
            !== {1'b0, 1'b0, 6'b000001, 1'b0, 7'h3F}) begin
            failures++;
            $display("FAIL midrun_reset got=%b_%b_%b_%b_%h", bus.o_tick, bus.o_wrap,
                     bus.o_seg_enb, bus.o_seg_dp, bus.o_seg);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) bus.i_nco_num = NCO_W'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) bus.i_up_dn = 1'($urandom_range(0, 1));
            bus.i_hold  = ($urandom_range(0, 7) == 0);
            bus.i_clear = ($urandom_range(0, 99) == 0);
            if (c % 97 == 0) bus.i_blank_lz = 1'($urandom_range(0, 1));
            rst_n = !($urandom_range(0, 999) == 0);
            @(negedge clk);
            checks++;
            if ({bus.o_tick, bus.o_wrap, bus.o_seg_enb, bus.o_seg_dp, bus.o_seg}
                !== {m_tick, m_wrap, m_enb, m_dp, m_seg}) begin
                failures++;
                $display("FAIL rand_model c=%0d got=%b%b_%b_%b_%h want=%b%b_%b_%b_%h", c,
                         bus.o_tick, bus.o_wrap, bus.o_seg_enb, bus.o_seg_dp, bus.o_seg,
                         m_tick, m_wrap, m_enb, m_dp, m_seg);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_clear_hold();
        test_scan_decode();
        test_blank();
        test_retune_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
